// File: rtl/writeback_stage_if.sv
// -----------------------------------------------------------------------------
// writeback_stage_if
// Bundles the retiring-instruction bus from the memory stage, the data-memory
// read response, the error-clear input and the register-file write port of the
// writeback stage.
//
// Signals (directions seen from the writeback stage):
//   wb_i_ce, wb_i_opcode, wb_i_reg_wr, wb_i_memtoreg, wb_i_jal, wb_i_addr_rd,
//   wb_i_alu_value, wb_i_pc, wb_i_byte_off   : retiring instruction (in)
//   wb_i_mem_ack, wb_i_mem_rdata             : memory read response (in)
//   wb_i_err_clr                             : clears the sticky error (in)
//   wb_o_ready, wb_o_stall                   : upstream flow control (out)
//   wb_o_reg_wr, wb_o_addr_rd, wb_o_data_rd  : register-file write port (out)
//   wb_o_err                                 : sticky memory-timeout flag (out)
//
// Modports:
//   master : the driving side (memory stage / memory / register file)
//   slave  : the writeback stage itself
// -----------------------------------------------------------------------------
interface writeback_stage_if #(
    parameter int DWIDTH       = 32,
    parameter int AWIDTH       = 5,
    parameter int OPCODE_WIDTH = 6
);
    logic                    wb_i_ce;
    logic                    wb_o_ready;
    logic [OPCODE_WIDTH-1:0] wb_i_opcode;
    logic                    wb_i_reg_wr;
    logic                    wb_i_memtoreg;
    logic                    wb_i_jal;
    logic [AWIDTH-1:0]       wb_i_addr_rd;
    logic [DWIDTH-1:0]       wb_i_alu_value;
    logic [DWIDTH-1:0]       wb_i_pc;
    logic [1:0]              wb_i_byte_off;
    logic                    wb_i_mem_ack;
    logic [DWIDTH-1:0]       wb_i_mem_rdata;
    logic                    wb_i_err_clr;
    logic                    wb_o_reg_wr;
    logic [AWIDTH-1:0]       wb_o_addr_rd;
    logic [DWIDTH-1:0]       wb_o_data_rd;
    logic                    wb_o_stall;
    logic                    wb_o_err;

    modport master (
        output wb_i_ce, wb_i_opcode, wb_i_reg_wr, wb_i_memtoreg, wb_i_jal,
               wb_i_addr_rd, wb_i_alu_value, wb_i_pc, wb_i_byte_off,
               wb_i_mem_ack, wb_i_mem_rdata, wb_i_err_clr,
        input  wb_o_ready, wb_o_reg_wr, wb_o_addr_rd, wb_o_data_rd,
               wb_o_stall, wb_o_err
    );

    modport slave (
        input  wb_i_ce, wb_i_opcode, wb_i_reg_wr, wb_i_memtoreg, wb_i_jal,
               wb_i_addr_rd, wb_i_alu_value, wb_i_pc, wb_i_byte_off,
               wb_i_mem_ack, wb_i_mem_rdata, wb_i_err_clr,
        output wb_o_ready, wb_o_reg_wr, wb_o_addr_rd, wb_o_data_rd,
               wb_o_stall, wb_o_err
    );
endinterface

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// Final pipeline stage. Accepts one retiring instruction per cycle, selects its
// result (link value, extracted load data or ALU value) and drives the
// register-file write port. Loads wait in WAIT_MEM for a memory acknowledge,
// stalling upstream; a load not acknowledged within TIMEOUT cycles is dropped
// and raises a sticky error flag.
//
// Ports:
//   wb_clk  : clock
//   wb_rst  : asynchronous, active-low reset
//   wb_if   : writeback_stage_if.slave (instruction bus, memory response,
//             error clear, flow control, register-file write port, error)
//
// All outputs are taken from registered state only.
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int DWIDTH       = 32,
    parameter int AWIDTH       = 5,
    parameter int OPCODE_WIDTH = 6,
    parameter int TIMEOUT      = 16
) (
    input logic              wb_clk,
    input logic              wb_rst,
    writeback_stage_if.slave wb_if
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [OPCODE_WIDTH-1:0] OP_LB  = OPCODE_WIDTH'(32'h20);
    localparam logic [OPCODE_WIDTH-1:0] OP_LH  = OPCODE_WIDTH'(32'h21);
    localparam logic [OPCODE_WIDTH-1:0] OP_LBU = OPCODE_WIDTH'(32'h24);
    localparam logic [OPCODE_WIDTH-1:0] OP_LHU = OPCODE_WIDTH'(32'h25);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    state_t                  state_q,    state_d;
    logic [CW-1:0]           cnt_q,      cnt_d;
    logic [OPCODE_WIDTH-1:0] opcode_q,   opcode_d;
    logic                    reg_wr_q,   reg_wr_d;
    logic [AWIDTH-1:0]       addr_rd_q,  addr_rd_d;
    logic [1:0]              byte_off_q, byte_off_d;
    logic                    out_wr_q,   out_wr_d;
    logic [AWIDTH-1:0]       out_addr_q, out_addr_d;
    logic [DWIDTH-1:0]       out_data_q, out_data_d;
    logic                    err_q,      err_d;

    logic accept;
    logic timeout_hit;

    // Little-endian lane extraction of a loaded word.
    function automatic logic [DWIDTH-1:0] load_extract(
        input logic [OPCODE_WIDTH-1:0] op,
        input logic [1:0]              off,
        input logic [DWIDTH-1:0]       word
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DWIDTH-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (op)
            OP_LB:   r = {{(DWIDTH-8){b[7]}}, b};
            OP_LBU:  r = {{(DWIDTH-8){1'b0}}, b};
            OP_LH:   r = {{(DWIDTH-16){h[15]}}, h};
            OP_LHU:  r = {{(DWIDTH-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            opcode_q   <= '0;
            reg_wr_q   <= 1'b0;
            addr_rd_q  <= '0;
            byte_off_q <= '0;
            out_wr_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opcode_q   <= opcode_d;
            reg_wr_q   <= reg_wr_d;
            addr_rd_q  <= addr_rd_d;
            byte_off_q <= byte_off_d;
            out_wr_q   <= out_wr_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
        end
    end

    // The committed address/data/enable are resolved on the transition into
    // COMMIT and held in dedicated output registers, so a following load can
    // overwrite the captured fields while the write port keeps its last value.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opcode_d    = opcode_q;
        reg_wr_d    = reg_wr_q;
        addr_rd_d   = addr_rd_q;
        byte_off_d  = byte_off_q;
        out_wr_d    = 1'b0;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        accept      = 1'b0;
        timeout_hit = 1'b0;

        case (state_q)
            IDLE, COMMIT: begin
                state_d = IDLE;
                accept  = wb_if.wb_i_ce;
            end
            WAIT_MEM: begin
                if (wb_if.wb_i_mem_ack) begin
                    state_d    = COMMIT;
                    cnt_d      = '0;
                    out_wr_d   = reg_wr_q && (addr_rd_q != '0);
                    out_addr_d = addr_rd_q;
                    out_data_d = load_extract(opcode_q, byte_off_q,
                                              wb_if.wb_i_mem_rdata);
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            opcode_d   = wb_if.wb_i_opcode;
            reg_wr_d   = wb_if.wb_i_reg_wr;
            addr_rd_d  = wb_if.wb_i_addr_rd;
            byte_off_d = wb_if.wb_i_byte_off;
            if (wb_if.wb_i_memtoreg && !wb_if.wb_i_jal) begin
                state_d = WAIT_MEM;
                cnt_d   = '0;
            end else begin
                // Link value wins over ALU; memtoreg with jal never waits.
                state_d    = COMMIT;
                out_wr_d   = wb_if.wb_i_reg_wr && (wb_if.wb_i_addr_rd != '0);
                out_addr_d = wb_if.wb_i_addr_rd;
                out_data_d = wb_if.wb_i_jal ? (wb_if.wb_i_pc + DWIDTH'(4))
                                            : wb_if.wb_i_alu_value;
            end
        end

        // Set has priority over clear.
        if (timeout_hit)
            err_d = 1'b1;
        else if (wb_if.wb_i_err_clr)
            err_d = 1'b0;
        else
            err_d = err_q;
    end

    assign wb_if.wb_o_stall   = (state_q == WAIT_MEM);
    assign wb_if.wb_o_ready   = (state_q != WAIT_MEM);
    assign wb_if.wb_o_reg_wr  = out_wr_q;
    assign wb_if.wb_o_addr_rd = out_addr_q;
    assign wb_if.wb_o_data_rd = out_data_q;
    assign wb_if.wb_o_err     = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    localparam int TIMEOUT = 16;

    logic clk;
    logic rst_n;

    writeback_stage_if #(.DWIDTH(32), .AWIDTH(5), .OPCODE_WIDTH(6)) bus ();

    writeback_stage #(
        .DWIDTH(32),
        .AWIDTH(5),
        .OPCODE_WIDTH(6),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk(clk),
        .wb_rst(rst_n),
        .wb_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        ce;
        logic [5:0]  op;
        logic        rw;
        logic        m2r;
        logic        jal;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [1:0]  off;
        logic        ack;
        logic [31:0] rdata;
        logic        e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_stall;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic ce, input logic [5:0] op, input logic rw, input logic m2r,
        input logic jal, input logic [4:0] rd, input logic [31:0] alu,
        input logic [31:0] pc, input logic [1:0] off, input logic ack,
        input logic [31:0] rdata, input logic e_wr, input logic [4:0] e_rd,
        input logic [31:0] e_data, input logic e_stall);
        vec_t v;
        v.ce = ce; v.op = op; v.rw = rw; v.m2r = m2r; v.jal = jal; v.rd = rd;
        v.alu = alu; v.pc = pc; v.off = off; v.ack = ack; v.rdata = rdata;
        v.e_wr = e_wr; v.e_rd = e_rd; v.e_data = e_data; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.wb_i_ce        = 1'b0;
        bus.wb_i_opcode    = '0;
        bus.wb_i_reg_wr    = 1'b0;
        bus.wb_i_memtoreg  = 1'b0;
        bus.wb_i_jal       = 1'b0;
        bus.wb_i_addr_rd   = '0;
        bus.wb_i_alu_value = '0;
        bus.wb_i_pc        = '0;
        bus.wb_i_byte_off  = '0;
        bus.wb_i_mem_ack   = 1'b0;
        bus.wb_i_mem_rdata = '0;
        bus.wb_i_err_clr   = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        bus.wb_i_ce        = v.ce;
        bus.wb_i_opcode    = v.op;
        bus.wb_i_reg_wr    = v.rw;
        bus.wb_i_memtoreg  = v.m2r;
        bus.wb_i_jal       = v.jal;
        bus.wb_i_addr_rd   = v.rd;
        bus.wb_i_alu_value = v.alu;
        bus.wb_i_pc        = v.pc;
        bus.wb_i_byte_off  = v.off;
        bus.wb_i_mem_ack   = v.ack;
        bus.wb_i_mem_rdata = v.rdata;
        bus.wb_i_err_clr   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_stall"}, 32'(bus.wb_o_stall), 32'd0);
        chk({tag, "_ready"}, 32'(bus.wb_o_ready), 32'd1);
        chk({tag, "_wr"},    32'(bus.wb_o_reg_wr), 32'd0);
        chk({tag, "_addr"},  32'(bus.wb_o_addr_rd), 32'd0);
        chk({tag, "_data"},  bus.wb_o_data_rd, 32'd0);
        chk({tag, "_err"},   32'(bus.wb_o_err), 32'd0);
    endtask

    // Reference load extraction written with shifts and plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [5:0] op,
                                             input logic [1:0] off,
                                             input logic [31:0] w);
        int unsigned bt, hw, sh;
        sh = 8 * int'(off);
        bt = (w >> sh) & 32'hFF;
        sh = 16 * (int'(off) / 2);
        hw = (w >> sh) & 32'hFFFF;
        case (op)
            6'h20:   return (bt >= 128) ? bt + 32'hFFFF_FF00 : bt;
            6'h24:   return bt;
            6'h21:   return (hw >= 32768) ? hw + 32'hFFFF_0000 : hw;
            6'h25:   return hw;
            default: return w;
        endcase
    endfunction

    initial begin
        int nstall;
        bit saw_wr;
        // Random-phase model state.
        bit          m_wait;
        int          m_k;
        int          m_ackdly;
        logic [5:0]  m_op;
        logic [4:0]  m_rd;
        logic        m_rw;
        logic [1:0]  m_off;
        logic        m_wr;
        logic [4:0]  m_addr;
        logic [31:0] m_data;
        logic        m_err;
        logic [5:0]  ops[6];

        drive_idle();
        rst_n = 1'b0;
        #2;
        chk_reset_vals("async_rst");
        step();
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        tbl.push_back(mk(1, 6'h00, 1, 0, 0, 5'd5, 32'h1234, 0, 0, 0, 0,           1, 5'd5, 32'h1234, 0));
        tbl.push_back(mk(1, 6'h00, 1, 0, 0, 5'd6, 32'h1, 0, 0, 0, 0,              1, 5'd6, 32'h1, 0));
        tbl.push_back(mk(1, 6'h00, 1, 0, 0, 5'd0, 32'hDEAD, 0, 0, 0, 0,           0, 5'd0, 0, 0));
        tbl.push_back(mk(1, 6'h00, 1, 0, 0, 5'd7, 32'h77, 0, 0, 1, 32'hFFFF_FFFF, 1, 5'd7, 32'h77, 0));
        tbl.push_back(mk(1, 6'h23, 1, 1, 1, 5'd31, 32'h5555, 32'h0040_0010, 0, 0, 0, 1, 5'd31, 32'h0040_0014, 0));
        // lb off=2, ack on the fourth WAIT cycle; ce during WAIT is ignored
        tbl.push_back(mk(1, 6'h20, 1, 1, 0, 5'd8, 32'h99, 0, 2, 0, 0,             0, 0, 0, 1));
        tbl.push_back(mk(1, 6'h00, 1, 0, 0, 5'd9, 32'hBAD, 0, 0, 0, 0,            0, 0, 0, 1));
        tbl.push_back(mk(1, 6'h00, 1, 0, 0, 5'd9, 32'hBAD, 0, 0, 0, 0,            0, 0, 0, 1));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0,                  0, 0, 0, 1));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 5'd0, 0, 0, 0, 1, 32'h1280_FF00,      1, 5'd8, 32'hFFFF_FF80, 0));
        // lbu off=2, same timing
        tbl.push_back(mk(1, 6'h24, 1, 1, 0, 5'd9, 0, 0, 2, 0, 0,                  0, 0, 0, 1));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0,                  0, 0, 0, 1));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0,                  0, 0, 0, 1));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0,                  0, 0, 0, 1));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 5'd0, 0, 0, 0, 1, 32'h1280_FF00,      1, 5'd9, 32'h0000_0080, 0));
        // lh off=3 (byte_off[0] ignored), immediate ack
        tbl.push_back(mk(1, 6'h21, 1, 1, 0, 5'd10, 0, 0, 3, 0, 0,                 0, 0, 0, 1));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 5'd0, 0, 0, 0, 1, 32'h8001_0000,      1, 5'd10, 32'hFFFF_8001, 0));
        // lhu off=1
        tbl.push_back(mk(1, 6'h25, 1, 1, 0, 5'd11, 0, 0, 1, 0, 0,                 0, 0, 0, 1));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 5'd0, 0, 0, 0, 1, 32'h1234_8001,      1, 5'd11, 32'h0000_8001, 0));
        // lw off=2
        tbl.push_back(mk(1, 6'h23, 1, 1, 0, 5'd12, 0, 0, 2, 0, 0,                 0, 0, 0, 1));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 5'd0, 0, 0, 0, 1, 32'hCAFE_BABE,      1, 5'd12, 32'hCAFE_BABE, 0));
        // lb off=3, positive byte
        tbl.push_back(mk(1, 6'h20, 1, 1, 0, 5'd14, 0, 0, 3, 0, 0,                 0, 0, 0, 1));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 5'd0, 0, 0, 0, 1, 32'h7F00_FFFF,      1, 5'd14, 32'h0000_007F, 0));
        // idle, then non-writing instruction, then load to $0
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0,                  0, 0, 0, 0));
        tbl.push_back(mk(1, 6'h00, 0, 0, 0, 5'd13, 32'h42, 0, 0, 0, 0,            0, 0, 0, 0));
        tbl.push_back(mk(1, 6'h23, 1, 1, 0, 5'd0, 0, 0, 0, 0, 0,                  0, 0, 0, 1));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 5'd0, 0, 0, 0, 1, 32'h1111_2222,      0, 0, 0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i]);
            step();
            chk($sformatf("v%0d_stall", i), 32'(bus.wb_o_stall), 32'(tbl[i].e_stall));
            chk($sformatf("v%0d_ready", i), 32'(bus.wb_o_ready), 32'(!tbl[i].e_stall));
            chk($sformatf("v%0d_wr", i),    32'(bus.wb_o_reg_wr), 32'(tbl[i].e_wr));
            chk($sformatf("v%0d_err", i),   32'(bus.wb_o_err), 32'd0);
            if (tbl[i].e_wr) begin
                chk($sformatf("v%0d_addr", i), 32'(bus.wb_o_addr_rd), 32'(tbl[i].e_rd));
                chk($sformatf("v%0d_data", i), bus.wb_o_data_rd, tbl[i].e_data);
            end
        end

        // ---------------- timeout, sticky error, set-beats-clear ----------------
        drive_idle();
        bus.wb_i_ce = 1'b1; bus.wb_i_opcode = 6'h23; bus.wb_i_reg_wr = 1'b1;
        bus.wb_i_memtoreg = 1'b1; bus.wb_i_addr_rd = 5'd3; bus.wb_i_err_clr = 1'b1;
        step();
        nstall = 0;
        saw_wr = 1'b0;
        chk("to_err_during_wait", 32'(bus.wb_o_err), 32'd0);
        for (int i = 0; i < 40 && bus.wb_o_stall; i++) begin
            nstall++;
            if (bus.wb_o_reg_wr) saw_wr = 1'b1;
            drive_idle();
            bus.wb_i_err_clr = 1'b1;
            step();
        end
        chk("to_stall_cycles", 32'(nstall), 32'(TIMEOUT));
        chk("to_no_write", 32'(saw_wr), 32'd0);
        chk("to_wr_after", 32'(bus.wb_o_reg_wr), 32'd0);
        chk("to_ready_after", 32'(bus.wb_o_ready), 32'd1);
        chk("to_err_set_wins", 32'(bus.wb_o_err), 32'd1);
        drive_idle();
        step();
        chk("to_err_sticky", 32'(bus.wb_o_err), 32'd1);
        bus.wb_i_err_clr = 1'b1;
        step();
        chk("to_err_cleared", 32'(bus.wb_o_err), 32'd0);
        drive_idle();

        // ---------------- reset in the middle of WAIT_MEM ----------------
        bus.wb_i_ce = 1'b1; bus.wb_i_opcode = 6'h23; bus.wb_i_reg_wr = 1'b1;
        bus.wb_i_memtoreg = 1'b1; bus.wb_i_addr_rd = 5'd4;
        step();
        drive_idle();
        step();
        chk("mr_stall_before", 32'(bus.wb_o_stall), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("mr_async");
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.wb_i_mem_ack = 1'b1;
        bus.wb_i_mem_rdata = 32'hABCD_0123;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mr_post%0d_wr", i), 32'(bus.wb_o_reg_wr), 32'd0);
            chk($sformatf("mr_post%0d_stall", i), 32'(bus.wb_o_stall), 32'd0);
            chk($sformatf("mr_post%0d_err", i), 32'(bus.wb_o_err), 32'd0);
        end

        // ---------------- randomized run against a reference model ----------------
        do_reset();
        ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h00};
        m_wait = 0; m_k = 0; m_ackdly = 0; m_op = '0; m_rd = '0; m_rw = 0; m_off = '0;
        m_wr = 0; m_addr = '0; m_data = '0; m_err = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic set;
            bus.wb_i_ce        = ($urandom_range(0, 3) != 0);
            bus.wb_i_opcode    = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            bus.wb_i_reg_wr    = ($urandom_range(0, 4) != 0);
            bus.wb_i_memtoreg  = $urandom_range(0, 1) == 1;
            bus.wb_i_jal       = ($urandom_range(0, 7) == 0);
            bus.wb_i_addr_rd   = 5'($urandom);
            bus.wb_i_alu_value = $urandom;
            bus.wb_i_pc        = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            bus.wb_i_byte_off  = 2'($urandom);
            bus.wb_i_mem_rdata = $urandom;
            bus.wb_i_err_clr   = ($urandom_range(0, 15) == 0);
            bus.wb_i_mem_ack   = m_wait ? (m_k == m_ackdly) : ($urandom_range(0, 1) == 1);
            step();

            set  = 1'b0;
            m_wr = 1'b0;
            if (m_wait) begin
                if (bus.wb_i_mem_ack) begin
                    m_wait = 0;
                    m_wr   = m_rw && (m_rd != 0);
                    m_addr = m_rd;
                    m_data = ref_load(m_op, m_off, bus.wb_i_mem_rdata);
                end else if (m_k == TIMEOUT - 1) begin
                    m_wait = 0;
                    set    = 1'b1;
                end else begin
                    m_k++;
                end
            end else if (bus.wb_i_ce) begin
                if (bus.wb_i_memtoreg && !bus.wb_i_jal) begin
                    m_wait   = 1;
                    m_k      = 0;
                    m_ackdly = $urandom_range(0, TIMEOUT + 2);
                    m_op     = bus.wb_i_opcode;
                    m_rd     = bus.wb_i_addr_rd;
                    m_rw     = bus.wb_i_reg_wr;
                    m_off    = bus.wb_i_byte_off;
                end else begin
                    m_wr   = bus.wb_i_reg_wr && (bus.wb_i_addr_rd != 0);
                    m_addr = bus.wb_i_addr_rd;
                    m_data = bus.wb_i_jal ? bus.wb_i_pc + 32'd4 : bus.wb_i_alu_value;
                end
            end
            if (set) m_err = 1'b1;
            else if (bus.wb_i_err_clr) m_err = 1'b0;

            chk("rnd_stall", 32'(bus.wb_o_stall), 32'(m_wait));
            chk("rnd_ready", 32'(bus.wb_o_ready), 32'(!m_wait));
            chk("rnd_wr",    32'(bus.wb_o_reg_wr), 32'(m_wr));
            chk("rnd_addr",  32'(bus.wb_o_addr_rd), 32'(m_addr));
            chk("rnd_data",  bus.wb_o_data_rd, m_data);
            chk("rnd_err",   32'(bus.wb_o_err), 32'(m_err));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Accepts one retiring instruction per cycle from the memory stage, selects the result, and drives the register-file write port of the decoder stage (reg_wr / addr_rd / data_rd).
- Handles variable-latency data-memory read responses with a wait FSM, a timeout counter and an upstream stall.
- Performs load-data byte/halfword extraction and JAL link-value generation.

Parameters:
- DWIDTH, 32, data/PC width
- AWIDTH, 5, register address width
- OPCODE_WIDTH, 6, opcode width
- TIMEOUT, 16, max WAIT_MEM cycles before abort (>=2)

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  reset, asynchronous, active-low
- wb_i_ce  in  1  upstream instruction valid
- wb_o_ready  out  1  stage can accept this cycle
- wb_i_opcode  in  OPCODE_WIDTH  opcode of retiring instruction
- wb_i_reg_wr  in  1  instruction writes a register
- wb_i_memtoreg  in  1  result comes from memory
- wb_i_jal  in  1  link write
- wb_i_addr_rd  in  AWIDTH  destination register
- wb_i_alu_value  in  DWIDTH  ALU result
- wb_i_pc  in  DWIDTH  PC of instruction
- wb_i_byte_off  in  2  load address bits [1:0]
- wb_i_mem_ack  in  1  memory read data valid
- wb_i_mem_rdata  in  DWIDTH  memory read word
- wb_i_err_clr  in  1  clears wb_o_err
- wb_o_reg_wr  out  1  register-file write enable
- wb_o_addr_rd  out  AWIDTH  write address
- wb_o_data_rd  out  DWIDTH  write data
- wb_o_stall  out  1  upstream must hold
- wb_o_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset (wb_rst=0, async):
  - State goes to IDLE. Counter and all captured fields clear.
  - Reset values: wb_o_reg_wr=0, wb_o_addr_rd=0, wb_o_data_rd=0, wb_o_stall=0, wb_o_err=0, wb_o_ready=1.
  - Reset mid-WAIT_MEM abandons the load and performs no write.
- Outputs depend only on registered state. There is no combinational path from any input to any output.
- wb_o_stall = (state==WAIT_MEM); wb_o_ready = !wb_o_stall.
- IDLE:
  - If ce=1, capture opcode, reg_wr, memtoreg, jal, addr_rd, alu_value, pc, byte_off.
  - Next state is WAIT_MEM if memtoreg=1 and jal=0; otherwise COMMIT.
- WAIT_MEM:
  - Counter increments each cycle; ack is sampled only in this state.
  - On ack=1: capture the extracted load data, go to COMMIT, clear the counter.
  - If counter==TIMEOUT-1 and ack=0: set err, go to IDLE with no write, clear the counter.
  - ce is ignored in this state (upstream is stalled).
- COMMIT:
  - wb_o_reg_wr = reg_wr_q && (addr_rd_q != 0) for exactly this cycle. wb_o_addr_rd and wb_o_data_rd are valid this cycle.
  - ready=1. If ce=1, capture the next instruction and branch exactly as from IDLE; otherwise go to IDLE.
- Outside COMMIT: wb_o_reg_wr=0; addr/data hold their last values.
- Latency and throughput:
  - Non-load accepted in cycle N is written in cycle N+1.
  - Back-to-back non-loads retire at 1 per cycle.
  - Load whose ack arrives in WAIT_MEM cycle k is written in the cycle after ack.
- Data select priority: jal_q -> pc_q+4 (modulo 2^DWIDTH); memtoreg_q -> extracted load; else alu_value_q.
- JAL uses the captured addr_rd. Decode sets it to 31.
- Load extraction, little-endian (byte lane = byte_off):
  - 0x20 lb: byte sign-extended.
  - 0x24 lbu: byte zero-extended.
  - 0x21 lh: halfword at byte_off[1], sign-extended; byte_off[0] ignored.
  - 0x25 lhu: as lh, zero-extended.
  - 0x23 lw, and any other opcode: full word.
- Writes to $0 are suppressed (reg_wr low), but the instruction still occupies COMMIT.
- wb_o_err: set on timeout; cleared by wb_i_err_clr. If set and clear occur in the same cycle, set wins.

Test Plan:
- Reset asserted mid-WAIT_MEM, then released -> wb_o_stall=0, ready=1, no reg_wr pulse, err=0.
- ADD ($5, alu=0x0000_1234) in cycle N, then ADD ($6, alu=0x0000_0001) in N+1 -> reg_wr in N+1 (addr 5, data 0x1234) and N+2 (addr 6, data 1); ready stays 1 throughout.
- lb op 0x20, off=2, rdata=0x1280_FF00, ack after 3 WAIT cycles -> stall high 3 cycles plus the ack cycle; then write data 0xFFFF_FF80. Same stimulus with lbu op 0x24 -> 0x0000_0080. lh off=3 with rdata 0x8001_0000 -> 0xFFFF_8001.
- JAL with pc=0x0040_0010, addr_rd=31, memtoreg=1 -> no wait; write 0x0040_0014 to $31 one cycle after accept.
- lw with no ack -> stall for exactly TIMEOUT (16) cycles, then IDLE, err=1, no write. Assert err_clr -> err=0 next cycle.
- ADD targeting $0 with reg_wr=1 -> no reg_wr pulse; the next instruction is still accepted in the COMMIT cycle.
